// File: rtl/gaosi_line_pkg.sv
// Shared defaults, counter width and state encoding for the Gaussian line scheduler.
package gaosi_line_pkg;

    localparam int unsigned WIDTH_DEF  = 320;
    localparam int unsigned HEIGHT_DEF = 240;
    localparam int unsigned BORDER_DEF = 2;
    localparam int unsigned CNT_W      = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gaosi_line_scheduler_valid_delay.sv
// DEPTH-stage valid shift register used to line up filter outputs with their
// enables; synchronous flush, asynchronous active-low reset.
module valid_delay
    import gaosi_line_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic din_i,
    output logic dout_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = '0;
        if (!flush_i) begin
            sr_d[0] = din_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/gaosi_line_scheduler.sv
// Frame sequencer for the Gaussian filter: feeds pixels, realigns filter output,
// assembles rows and hands lines out on valid/ready. Optional macro: FILTER_BORDER_MASK_EN.
module gaosi_line_scheduler
    import gaosi_line_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned HEIGHT   = HEIGHT_DEF,
    parameter int unsigned BORDER   = BORDER_DEF,
    parameter int unsigned FILT_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic             pix_in,
    output logic             filt_en,
    output logic             filt_din,
    input  logic             filt_dout,
    output logic             line_valid,
    input  logic             line_ready,
    output logic [WIDTH-1:0] line_data,
    output logic [8:0]       line_row,
    output logic             frame_done,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] ROWS     = CNT_W'(HEIGHT);
    localparam logic [CNT_W-1:0] BORD     = CNT_W'(BORDER);
    localparam logic [CNT_W-1:0] COL_HI   = CNT_W'(WIDTH - BORDER);
    localparam logic [CNT_W-1:0] ROW_HI   = CNT_W'(HEIGHT - BORDER);
`ifdef FILTER_BORDER_MASK_EN
    localparam logic MASK_EN = 1'b1;
`else
    localparam logic MASK_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_col_q, in_col_d, in_row_q, in_row_d;
    logic [CNT_W-1:0] out_col_q, out_col_d, out_row_q, out_row_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] done_row_q, done_row_d;
    logic             filt_en_q, filt_en_d, filt_din_q, filt_din_d;
    logic             line_valid_q, line_valid_d;
    logic [WIDTH-1:0] line_data_q, line_data_d;
    logic [CNT_W-1:0] line_row_q, line_row_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;

    logic cap_v;
    logic in_border;
    logic cap_bit;
    logic hs;

    valid_delay #(
        .DEPTH (FILT_LAT)
    ) u_valid_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (frame_start),
        .din_i   (filt_en_q),
        .dout_o  (cap_v)
    );

    assign in_border = (out_col_q < BORD) || (out_col_q >= COL_HI) ||
                       (out_row_q < BORD) || (out_row_q >= ROW_HI);
    assign cap_bit   = filt_dout & ~(in_border & MASK_EN);
    assign hs        = line_valid_q & line_ready;

    always_comb begin
        state_d      = state_q;
        in_col_d     = in_col_q;
        in_row_d     = in_row_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        acc_d        = acc_q;
        done_d       = 1'b0;
        done_row_d   = done_row_q;
        filt_en_d    = 1'b0;
        filt_din_d   = filt_din_q;
        line_valid_d = line_valid_q;
        line_data_d  = line_data_q;
        line_row_d   = line_row_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        if (frame_start) begin
            state_d      = RUN;
            in_col_d     = '0;
            in_row_d     = '0;
            out_col_d    = '0;
            out_row_d    = '0;
            acc_d        = '0;
            line_valid_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    // Input side stops once a full frame of pixels has been taken.
                    if (pix_valid && (in_row_q < ROWS)) begin
                        filt_en_d  = 1'b1;
                        filt_din_d = pix_in;
                        if (in_col_q == LAST_COL) begin
                            in_col_d = '0;
                            in_row_d = in_row_q + CNT_W'(1);
                        end else begin
                            in_col_d = in_col_q + CNT_W'(1);
                        end
                    end

                    if (cap_v) begin
                        acc_d[out_col_q] = cap_bit;
                        if (out_col_q == LAST_COL) begin
                            out_col_d  = '0;
                            out_row_d  = out_row_q + CNT_W'(1);
                            done_d     = 1'b1;
                            done_row_d = out_row_q;
                        end else begin
                            out_col_d = out_col_q + CNT_W'(1);
                        end
                    end

                    if (hs) begin
                        line_valid_d = 1'b0;
                        if (line_row_q == LAST_ROW) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end
                    end

                    // Row completed last cycle: acc_q now holds the whole row.
                    if (done_q) begin
                        if (!line_valid_q || line_ready) begin
                            line_valid_d = 1'b1;
                            line_data_d  = acc_q;
                            line_row_d   = done_row_q;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_col_q     <= '0;
            in_row_q     <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            acc_q        <= '0;
            done_q       <= 1'b0;
            done_row_q   <= '0;
            filt_en_q    <= 1'b0;
            filt_din_q   <= 1'b0;
            line_valid_q <= 1'b0;
            line_data_q  <= '0;
            line_row_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_col_q     <= in_col_d;
            in_row_q     <= in_row_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            acc_q        <= acc_d;
            done_q       <= done_d;
            done_row_q   <= done_row_d;
            filt_en_q    <= filt_en_d;
            filt_din_q   <= filt_din_d;
            line_valid_q <= line_valid_d;
            line_data_q  <= line_data_d;
            line_row_q   <= line_row_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign filt_en    = filt_en_q;
    assign filt_din   = filt_din_q;
    assign line_valid = line_valid_q;
    assign line_data  = line_data_q;
    assign line_row   = line_row_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_gaosi_line_scheduler.sv
// Scoreboard bench for gaosi_line_scheduler: pixel-level reference model feeds
// expected lines and line_valid rise times; a negedge monitor checks handshakes.
module tb_gaosi_line_scheduler;

    localparam int W = 320;
    localparam int H = 10;
    localparam int B = 2;
    localparam int L = 3;
`ifdef FILTER_BORDER_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_start = 1'b0;
    logic         pix_valid = 1'b0;
    logic         pix_in = 1'b0;
    logic         filt_en, filt_din, filt_dout;
    logic         line_valid;
    logic         line_ready = 1'b0;
    logic [W-1:0] line_data;
    logic [8:0]   line_row;
    logic         frame_done, overflow;

    gaosi_line_scheduler #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .BORDER   (B),
        .FILT_LAT (L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .filt_en     (filt_en),
        .filt_din    (filt_din),
        .filt_dout   (filt_dout),
        .line_valid  (line_valid),
        .line_ready  (line_ready),
        .line_data   (line_data),
        .line_row    (line_row),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Stand-in filter: identity with L cycles of latency.
    logic [L-1:0] fpipe = '0;
    always @(posedge clk) fpipe <= {fpipe[L-2:0], filt_din};
    assign filt_dout = fpipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk_v(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b", nm, act, exp);
        end
    endtask

    task automatic fail_note(input string nm, input string act, input string exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual %s required %s", nm, act, exp);
    endtask

    // Reference model
    typedef struct {
        int           row;
        logic [W-1:0] data;
    } line_t;

    line_t        exp_q[$];
    int           rise_q[$];
    bit           in_frame = 1'b0;
    int           mcol = 0;
    int           mrow = 0;
    logic [W-1:0] cur = '0;

    function automatic bit masked(input int r, input int c);
        bit border;
        border = (c < B) || (c >= W - B) || (r < B) || (r >= H - B);
        return MASK && border;
    endfunction

    task automatic send_pix(input logic p, input int gap);
        pix_valid = 1'b1;
        pix_in    = p;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        if (in_frame && mrow < H) begin
            cur[mcol] = masked(mrow, mcol) ? 1'b0 : p;
            mcol++;
            if (mcol == W) begin
                exp_q.push_back('{mrow, cur});
                rise_q.push_back(cyc + 2 + L);
                mcol = 0;
                mrow++;
            end
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor
    bit    mon_en = 1'b1;
    bit    lv_prev = 1'b0;
    bit    fd_pend = 1'b0;
    bit    fd_next = 1'b0;
    int    lines_frame = 0;
    int    fd_count = 0;
    line_t e;

    always @(negedge clk) begin
        fd_next = 1'b0;
        if (mon_en) begin
            if (line_valid && !lv_prev) begin
                if (rise_q.size() == 0) fail_note("line_valid_rise", "rise", "no rise");
                else chk_i("line_valid_rise_cycle", cyc, rise_q.pop_front());
            end
            if (line_valid && line_ready) begin
                lines_frame++;
                if (exp_q.size() == 0) begin
                    fail_note("line_handshake", "unexpected line", "no line");
                end else begin
                    e = exp_q.pop_front();
                    chk_i("line_row", int'(line_row), e.row);
                    chk_v("line_data", line_data, e.data);
                    if (e.row == H - 1) fd_next = 1'b1;
                end
            end
            if (fd_pend || frame_done) chk_b("frame_done", frame_done, fd_pend);
            if (frame_done) fd_count++;
        end
        fd_pend = fd_next;
        lv_prev = line_valid;
    end

    bit rdy_rand = 1'b0;
    bit rdy_fixed = 1'b1;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            line_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_fixed;
        end
    end

    task automatic start_frame();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        in_frame    = 1'b1;
        mcol        = 0;
        mrow        = 0;
        exp_q.delete();
        rise_q.delete();
        lines_frame = 0;
    endtask

    task automatic send_frame(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0:       send_pix(1'b1, 0);
                    1:       send_pix(1'($urandom_range(1)), 1);
                    default: send_pix(1'($urandom_range(1)), ($urandom_range(4) == 0) ? 1 : 0);
                endcase
            end
        end
    endtask

    task automatic end_frame(input string tag, input int fd_start);
        for (int i = 0; i < 3000; i++) begin
            if (fd_count != fd_start) break;
            @(posedge clk);
        end
        repeat (20) @(posedge clk);
        #1;
        chk_i({tag, "_frame_done_count"}, fd_count, fd_start + 1);
        chk_i({tag, "_lines"}, lines_frame, H);
        chk_i({tag, "_scoreboard_left"}, exp_q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk_b({tag, "_filt_en"}, filt_en, 1'b0);
        chk_b({tag, "_filt_din"}, filt_din, 1'b0);
        chk_b({tag, "_line_valid"}, line_valid, 1'b0);
        chk_v({tag, "_line_data"}, line_data, '0);
        chk_i({tag, "_line_row"}, int'(line_row), 0);
        chk_b({tag, "_frame_done"}, frame_done, 1'b0);
        chk_b({tag, "_overflow"}, overflow, 1'b0);
    endtask

    int    fd0;
    line_t e0;

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // IDLE ignores pixels
        for (int i = 0; i < 4; i++) begin
            send_pix(1'b1, 0);
            chk_b("idle_filt_en", filt_en, 1'b0);
        end

        // All-ones frame, ready held high
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        fd0 = fd_count;
        start_frame();
        send_frame(0);
        end_frame("ones", fd0);

        // Alternating pix_valid, random ready
        rdy_rand = 1'b1;
        fd0 = fd_count;
        start_frame();
        send_frame(1);
        end_frame("toggle", fd0);
        chk_b("no_overflow", overflow, 1'b0);

        // Reset in the middle of a frame
        start_frame();
        for (int i = 0; i < 3 * W + 50; i++) send_pix(1'($urandom_range(1)), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrun_reset");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_frame = 1'b0;
        exp_q.delete();
        rise_q.delete();
        for (int i = 0; i < 3; i++) begin
            send_pix(1'b1, 0);
            chk_b("post_reset_idle_filt_en", filt_en, 1'b0);
        end
        fd0 = fd_count;
        start_frame();
        send_frame(2);
        end_frame("after_reset", fd0);

        // Abort at row 5 column 100 with a line pending
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        start_frame();
        for (int i = 0; i < 4 * W + 20; i++) send_pix(1'($urandom_range(1)), 0);
        rdy_fixed = 1'b0;
        for (int i = 0; i < W - 20 + 100; i++) send_pix(1'($urandom_range(1)), 0);
        @(negedge clk);
        chk_b("pending_before_abort", line_valid, 1'b1);
        chk_i("pending_row_before_abort", int'(line_row), 4);
        @(posedge clk);
        #1;
        fd0 = fd_count;
        start_frame();
        @(negedge clk);
        chk_b("abort_clears_valid", line_valid, 1'b0);
        @(posedge clk);
        #1;
        rdy_rand = 1'b1;
        send_frame(2);
        end_frame("after_abort", fd0);

        // Overflow: two rows complete with ready low
        mon_en    = 1'b0;
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b0;
        start_frame();
        for (int i = 0; i < 2 * W; i++) send_pix(1'($urandom_range(1)), 0);
        e0 = exp_q[0];
        repeat (L + 4) @(posedge clk);
        @(negedge clk);
        chk_b("ovf_held_valid", line_valid, 1'b1);
        chk_i("ovf_held_row", int'(line_row), 0);
        chk_v("ovf_held_data", line_data, e0.data);
        chk_b("ovf_flag", overflow, 1'b1);
        @(posedge clk);
        #1;
        rdy_fixed = 1'b1;
        @(negedge clk);
        chk_b("ovf_handshake", line_valid & line_ready, 1'b1);
        chk_i("ovf_handshake_row", int'(line_row), 0);
        @(posedge clk);
        #1;
        rdy_fixed = 1'b0;
        @(negedge clk);
        chk_b("ovf_dropped_absent", line_valid, 1'b0);
        chk_b("ovf_still_set", overflow, 1'b1);
        @(posedge clk);
        #1;
        start_frame();
        @(negedge clk);
        chk_b("ovf_sticky_restart", overflow, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_b("ovf_cleared_by_reset", overflow, 1'b0);
        chk_b("valid_after_final_reset", line_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gaosi_line_scheduler.md
# gaosi_line_scheduler

Sequences the Gaussian filter over a binary pixel stream, one frame at a time. It tracks frame position with row and column counters and drives the filter's enable and data inputs. It compensates for filter latency, assembles each filtered row into a WIDTH-bit line with border masking, and hands completed lines downstream over a valid/ready handshake. It sits between the camera pixel interface and the line consumer, and owns the filter's input port.

## Interface
- WIDTH, 320, pixels per row
- HEIGHT, 240, rows per frame
- BORDER, 2, border width in pixels/rows masked to 0
- FILT_LAT, 2, filter latency in clk cycles from filt_en/filt_din to filt_dout, 1..8
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  sync pulse; starts or restarts a frame
- pix_valid  in  1  pix_in valid this cycle
- pix_in  in  1  binary pixel
- filt_en  out  1  filter advance enable
- filt_din  out  1  filter input pixel
- filt_dout  in  1  filter output pixel, valid FILT_LAT cycles after the matching filt_en
- line_valid  out  1  line_data/line_row hold a complete line
- line_ready  in  1  downstream accepts the line
- line_data  out  WIDTH  filtered line; bit c is column c
- line_row  out  9  row index of line_data
- frame_done  out  1  one-cycle pulse after the last line is accepted
- overflow  out  1  sticky; a completed line was dropped

## Operation
- States:
  - IDLE: frame_start moves to RUN and clears the counters.
  - RUN: collects pixels. After HEIGHT lines are handed off and the last is accepted, pulse frame_done and return to IDLE.
- Pixel input:
  - In RUN, each pix_valid registers pix_in into filt_din and asserts filt_en for 1 cycle.
  - pix_valid in IDLE is ignored; filt_en stays 0.
- Latency compensation:
  - A FILT_LAT-deep valid delay line tracks filter outputs.
  - Each delayed valid writes filt_dout into accumulator bit out_col, then increments out_col.
- Line completion:
  - At out_col == WIDTH-1, out_col wraps to 0 and out_row increments.
  - The accumulator is copied to line_data, with line_row = out_row, and line_valid is set.
- Handshake:
  - line_valid stays high until line_valid && line_ready.
  - line_data and line_row are stable while line_valid is high.
- Overflow:
  - A line that completes while line_valid is still high and line_ready is low is dropped.
  - The pending line is kept and overflow is set.
  - If line_ready is high in that same cycle, the new line replaces the old one and is not an overflow.
- frame_start while in RUN:
  - Aborts the frame and flushes the delay line.
  - Clears the counters, the accumulator and line_valid.
  - Restarts RUN; overflow is kept.
- overflow clears only on reset.

## Timing
- Reset values:
  - filt_en = 0, filt_din = 0, line_valid = 0, line_data = 0, line_row = 0, frame_done = 0, overflow = 0.
  - State = IDLE; all counters 0.
- Pixel accepted at edge t → filt_en high during cycle t+1 → filt_dout sampled at edge t+1+FILT_LAT.
- Last pixel of a row accepted at edge t → line_valid high from edge t+2+FILT_LAT.
- frame_done asserts the cycle after the handshake of row HEIGHT-1.
- There is no backpressure upstream; the throughput requirement is one accepted line per WIDTH pixels.

## Configuration
- FILTER_BORDER_MASK_EN defined:
  - When a bit is captured, it is forced to 0 if col<BORDER, col≥WIDTH-BORDER, row<BORDER or row≥HEIGHT-BORDER.
- Undefined: filt_dout is stored unmodified at every position.

## Structure
- Package gaosi_line_pkg holds:
  - WIDTH/HEIGHT/BORDER defaults
  - the state enum {IDLE, RUN}
  - the col/row counter widths (9 bits)
- Sub-module valid_delay:
  - parameterised FILT_LAT-deep shift register with synchronous flush and async reset.
  - Used for latency compensation.

## Test plan
- Reset mid-RUN (rst_n low 1 cycle) → all outputs 0, state IDLE, next frame_start begins at row 0, column 0.
- Continuous all-ones frame, line_ready=1, mask defined → line 2 data has bits [1:0] and [319:318] = 0, others 1; rows 0, 1, 238, 239 are all zero; exactly 240 lines, then one frame_done.
- Same frame with the mask undefined → every line is all ones.
- pix_valid toggling 1/0 each cycle → line_row increments by 1 per 320 accepted pixels; line_valid rises 2+FILT_LAT cycles after the 320th pixel.
- line_ready=0 across two line completions → first line is held, second dropped, overflow=1; next handshake returns line_row of the first line.
- frame_start at column 100 of row 5 → line_valid drops, no stale line is emitted, next line has line_row=0.
